// File: rtl/inverter_pkg.sv
// rtl/inverter_pkg.sv - shared constants and per-bit transform for inverter_pipe
//
// Purpose: transform mode encodings and the per-bit transform function used
// at the entry of the inverter_pipe datapath.
package inverter_pkg;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_INV      = 2'b01;
  localparam logic [1:0] MODE_XOR      = 2'b10;
  localparam logic [1:0] MODE_INV_MASK = 2'b11;

  // Works on one bit so that any WIDTH can be built by looping over bits
  // without padding to a fixed maximum width.
  function automatic logic apply_mode(input logic [1:0] mode,
                                      input logic       data,
                                      input logic       mask);
    logic res;
    case (mode)
      MODE_PASS: res = data;
      MODE_INV:  res = ~data;
      MODE_XOR:  res = data ^ mask;
      default:   res = ~data & mask;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inverter_stage.sv
// rtl/inverter_stage.sv - one valid/data register slice of the inverter pipeline
//
// Purpose: holds one beat; loads from upstream whenever it advances.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   up_valid       upstream offers a beat
//   up_data        upstream beat data
//   down_ready     downstream can take this stage's contents this cycle
//   valid, data    registered beat held by this stage
//   advance        this stage takes a new beat (or bubble) at the next edge
module inverter_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             advance
);

  // An empty stage always advances, which is what lets bubbles compress
  // while the stages further down are stalled.
  assign advance = ~valid | down_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (advance) begin
      valid <= up_valid;
      // Data only moves with a real beat; a bubble leaves the old word in place.
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/inverter_pipe.sv
// rtl/inverter_pipe.sv - pipelined per-beat selectable inverter with valid/ready streams
//
// Purpose: transforms each accepted word by its own mode/mask, carries it
// through DEPTH register stages and counts delivered beats.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mode, mask                 transform select and per-bit mask, taken with in_data
//   in_valid, in_ready, in_data   input stream
//   out_valid, out_ready, out_data output stream
//   beat_cnt                   delivered beats, modulo 2^CNT_W
module inverter_pipe
  import inverter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [WIDTH-1:0] entry_data;

  // The transform happens once, before stage 0, so mode and mask never need
  // to travel down the pipe.
  always_comb begin
    entry_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      entry_data[i] = apply_mode(mode, in_data[i], mask[i]);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_ready;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             adv;

    if (k == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = entry_data;
    end else begin : g_mid
      assign up_valid = g_stage[k-1].valid;
      assign up_data  = g_stage[k-1].data;
    end

    // Ready ripples back combinationally from out_ready through every stage.
    if (k == DEPTH - 1) begin : g_last
      assign down_ready = out_ready;
    end else begin : g_next
      assign down_ready = g_stage[k+1].adv;
    end

    inverter_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_ready),
      .valid      (valid),
      .data       (data),
      .advance    (adv)
    );
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = g_stage[DEPTH-1].valid;
  assign out_data  = g_stage[DEPTH-1].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inverter_pipe.sv
// tb/tb_inverter_pipe.sv - self-checking bench for inverter_pipe
module tb_inverter_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic [1:0]       mode;
  logic [WIDTH-1:0] mask;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      beat_cnt;

  logic             in_ready_w;
  logic             out_valid_w;
  logic [WIDTH-1:0] out_data_w;
  logic [3:0]       beat_cnt_w;

  inverter_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_cnt(beat_cnt)
  );

  // Same stimulus, narrow counter to exercise wrap-around.
  inverter_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .beat_cnt(beat_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               t;
  } beat_t;

  beat_t q[$];
  int    delivered;
  int    cyc;
  int    checks;
  int    errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] xform(input logic [1:0] m, input logic [WIDTH-1:0] d,
                                             input logic [WIDTH-1:0] k);
    case (m)
      2'd0:    return d;
      2'd1:    return ~d;
      2'd2:    return d ^ k;
      default: return ~d & k;
    endcase
  endfunction

  // One clock cycle, entered just after a falling edge. The model is a FIFO of
  // accepted beats stamped with their acceptance cycle: the oldest beat shows
  // once DEPTH cycles have elapsed, and input is refused only when DEPTH beats
  // are held and the consumer is stalling.
  task automatic step(input logic v, input logic [1:0] m, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] k, input logic ordy, output logic took);
    logic exp_rdy;
    logic exp_ov;
    in_valid  = v;
    mode      = m;
    in_data   = d;
    mask      = k;
    out_ready = ordy;
    #1;
    exp_rdy = !(q.size() == DEPTH && !ordy);
    exp_ov  = (q.size() > 0) && (cyc >= q[0].t + DEPTH);
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    check("out_valid_w", {63'd0, out_valid_w}, {63'd0, exp_ov});
    if (exp_ov) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
    end
    check("beat_cnt", 64'(beat_cnt), 64'(delivered % 65536));
    check("beat_cnt_w", 64'(beat_cnt_w), 64'(delivered % 16));
    took = v && exp_rdy;
    if (exp_ov && ordy) begin
      void'(q.pop_front());
      delivered++;
    end
    if (took) begin
      q.push_back('{xform(m, d, k), cyc});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] m, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] k, input logic ordy);
    logic took;
    int   n;
    took = 1'b0;
    n    = 0;
    while (!took && n < 20) begin
      step(1'b1, m, d, k, ordy, took);
      n++;
    end
    if (!took) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic took;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, ordy, took);
  endtask

  initial begin
    logic took;
    int   n;
    checks    = 0;
    errors    = 0;
    delivered = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 2'd0;
    mask      = '0;
    in_data   = '0;
    out_ready = 1'b0;

    @(negedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat, latency and value.
    send(2'b01, 8'h3C, 8'h00, 1'b1);
    idle(3, 1'b1);
    check("single_cnt", 64'(beat_cnt), 64'd1);

    // All four modes back-to-back.
    send(2'b00, 8'hA5, 8'h0F, 1'b1);
    send(2'b01, 8'hA5, 8'h0F, 1'b1);
    send(2'b10, 8'hA5, 8'h0F, 1'b1);
    send(2'b11, 8'hA5, 8'h0F, 1'b1);
    idle(4, 1'b1);
    check("modes_cnt", 64'(beat_cnt), 64'd5);

    // Backpressure: two fill the pipe, the third is refused while stalled.
    send(2'b00, 8'h01, 8'h00, 1'b0);
    send(2'b00, 8'h02, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, 8'h03, 8'h00, 1'b0, took);
      check("bp_refused", {63'd0, took}, 64'd0);
    end
    check("bp_hold_data", 64'(out_data), 64'h01);
    send(2'b00, 8'h03, 8'h00, 1'b1);
    send(2'b00, 8'h04, 8'h00, 1'b1);
    send(2'b00, 8'h05, 8'h00, 1'b1);
    idle(4, 1'b1);
    check("bp_cnt", 64'(beat_cnt), 64'd10);

    // Full pipe, accept and deliver in the same cycle.
    send(2'b10, 8'h11, 8'hFF, 1'b0);
    send(2'b10, 8'h22, 8'hFF, 1'b0);
    step(1'b1, 2'b10, 8'h33, 8'hFF, 1'b1, took);
    check("full_sim_took", {63'd0, took}, 64'd1);
    idle(4, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
           8'($urandom), $urandom_range(0, 2) != 0, took);
    end

    // Reset with beats in flight, asserted between edges.
    send(2'b01, 8'h0F, 8'h00, 1'b1);
    send(2'b01, 8'hF0, 8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    delivered = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1'b1);

    // Narrow counter wrap: 17 deliveries from reset.
    n = 0;
    while (delivered < 17 && n < 100) begin
      step(delivered + q.size() < 17, 2'($urandom_range(0, 3)), 8'($urandom),
           8'($urandom), 1'b1, took);
      n++;
    end
    #1;
    check("wrap_cnt_w", 64'(beat_cnt_w), 64'h1);
    check("wrap_cnt", 64'(beat_cnt), 64'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
